wb_burst_ram: RTL and testbench

WB_BURST_RAM -- requirements
Module: wb_burst_ram

---
 rtl/wb_burst_ram.sv | 131 +++++++++++++
 tb/tb_wb_burst_ram.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_ram.sv
// rtl/wb_burst_ram.sv - Wishbone classic/incrementing-burst single-port RAM slave
// First ack after wait_states extra cycles; read data comes from a one-cycle-ahead read address.
module wb_burst_ram #(
  parameter int adr_width   = 10,
  parameter int wait_states = 0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic [2:0]  wb_cti_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BEAT  = 2'd2;
  localparam logic [1:0] S_BURST = 2'd3;

  localparam logic [2:0] CTI_INC = 3'b010;
  localparam logic [2:0] CTI_END = 3'b111;

  localparam int                   DEPTH = 1 << adr_width;
  localparam logic [7:0]           WS8   = 8'(wait_states);
  localparam logic [adr_width-1:0] ONE   = 1;

  logic [1:0]           state;
  logic                 ack_reg;
  logic [7:0]           wait_cnt;
  logic [adr_width-1:0] addr;
  logic [adr_width-1:0] rd_addr;
  logic [adr_width-1:0] adr_idx;
  logic                 beat_done;
  logic                 unused_adr_bits;
  logic [31:0]          mem [DEPTH];

  assign adr_idx         = wb_adr_i[adr_width+1:2];
  assign unused_adr_bits = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0]};
  assign wb_ack_o        = ack_reg & wb_cyc_i & wb_stb_i;
  assign beat_done       = wb_ack_o;

  // Address the RAM will be read at for the next cycle's beat.
  always_comb begin
    rd_addr = addr;
    if (state == S_IDLE)
      rd_addr = adr_idx;
    else if (beat_done)
      rd_addr = addr + ONE;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= S_IDLE;
      ack_reg  <= 1'b0;
      addr     <= '0;
      wait_cnt <= '0;
    end else if (!wb_cyc_i) begin
      state   <= S_IDLE;
      ack_reg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (wb_stb_i) begin
            addr     <= adr_idx;
            wait_cnt <= WS8;
            if (wait_states > 0) begin
              state <= S_WAIT;
            end else begin
              state   <= S_BEAT;
              ack_reg <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 8'd1;
          if (wait_cnt == 8'd1) begin
            state   <= S_BEAT;
            ack_reg <= 1'b1;
          end
        end
        S_BEAT: begin
          if (beat_done) begin
            if (wb_cti_i == CTI_INC) begin
              state <= S_BURST;
              addr  <= addr + ONE;
            end else begin
              state   <= S_IDLE;
              ack_reg <= 1'b0;
            end
          end
        end
        S_BURST: begin
          if (beat_done) begin
            addr <= addr + ONE;
            if (wb_cti_i == CTI_END) begin
              state   <= S_IDLE;
              ack_reg <= 1'b0;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          ack_reg <= 1'b0;
        end
      endcase
    end
  end

  // Memory has no reset; a beat completing under reset is dropped.
  always_ff @(posedge sys_clk) begin
    if (beat_done && wb_we_i && !sys_rst) begin
      for (int i = 0; i < 4; i++) begin
        if (wb_sel_i[i])
          mem[addr][8*i +: 8] <= wb_dat_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      wb_dat_o <= '0;
    else
      wb_dat_o <= mem[rd_addr];
  end

endmodule

// File: tb/tb_wb_burst_ram.sv
// tb/tb_wb_burst_ram.sv - randomized bench for wb_burst_ram against a transaction-level memory model
// Two instances: a (adr_width 10, no wait states) and b (adr_width 4, 3 wait states).
module tb_wb_burst_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        use_b;
  logic        cyc_a, cyc_b, ack_a, ack_b, ack;
  logic [31:0] dat_a, dat_b, rdat;

  always #5 clk = ~clk;

  assign cyc_a = cyc & ~use_b;
  assign cyc_b = cyc & use_b;
  assign ack   = use_b ? ack_b : ack_a;
  assign rdat  = use_b ? dat_b : dat_a;

  wb_burst_ram #(.adr_width(10), .wait_states(0)) dut_a (
    .sys_clk(clk), .sys_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_a),
    .wb_sel_i(sel), .wb_cti_i(cti), .wb_we_i(we), .wb_cyc_i(cyc_a), .wb_stb_i(stb),
    .wb_ack_o(ack_a)
  );

  wb_burst_ram #(.adr_width(4), .wait_states(3)) dut_b (
    .sys_clk(clk), .sys_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_b),
    .wb_sel_i(sel), .wb_cti_i(cti), .wb_we_i(we), .wb_cyc_i(cyc_b), .wb_stb_i(stb),
    .wb_ack_o(ack_b)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] mdl   [2][1024];
  bit          known [2][1024];
  logic [31:0] bdat  [64];
  logic [3:0]  bsel  [64];
  logic [2:0]  cls_cti [3] = '{3'b000, 3'b001, 3'b111};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // One access of nb beats at word; optional master stall before beat stall_at, optional reset during beat rst_at.
  task automatic access(input bit wr, input int word, input int nb,
                        input int stall_at, input int stall_len, input int rst_at);
    int          d     = use_b ? 1 : 0;
    int          depth = use_b ? 16 : 1024;
    int          ws    = use_b ? 3 : 0;
    int          a     = word % depth;
    logic [31:0] mask  = 32'(depth * 4 - 1);
    @(posedge clk); #1;
    cyc   = 1'b1;
    stb   = 1'b1;
    we    = wr;
    adr   = ($urandom & ~mask) | 32'(a * 4);
    dat_w = bdat[0];
    sel   = bsel[0];
    cti   = (nb > 1) ? 3'b010 : cls_cti[$urandom_range(0, 2)];
    for (int c = 0; c <= ws; c++) begin
      @(negedge clk);
      check("first_ack_early", ack, 0);
      @(posedge clk); #1;
      adr = $urandom;
    end
    for (int b = 0; b < nb; b++) begin
      if (b == stall_at && stall_len > 0) begin
        stb = 1'b0;
        repeat (stall_len) begin
          @(negedge clk);
          check("stall_ack", ack, 0);
          @(posedge clk); #1;
        end
        stb = 1'b1;
      end
      if (b == rst_at) rst = 1'b1;
      @(negedge clk);
      check("beat_ack", ack, 1);
      if (known[d][a]) check(wr ? "wr_prior_dat" : "rd_dat", rdat, mdl[d][a]);
      @(posedge clk); #1;
      if (b == rst_at) begin
        rst = 1'b0;
        break;
      end
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (sel[i]) mdl[d][a][8*i +: 8] = dat_w[8*i +: 8];
        if (sel == 4'hF) known[d][a] = 1'b1;
      end
      a = (a + 1) % depth;
      if (b + 1 < nb) begin
        dat_w = bdat[b+1];
        sel   = bsel[b+1];
        cti   = (b + 1 == nb - 1) ? 3'b111 : 3'b010;
        adr   = $urandom;
      end
    end
    we = 1'b0;
    @(negedge clk);
    check("end_ack_low", ack, 0);
    @(posedge clk); #1;
    cyc = 1'b0;
    stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin
      bdat[i] = $urandom;
      bsel[i] = 4'hF;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; use_b = 1'b0;
    adr = '0; dat_w = '0; sel = '0; cti = '0;
    repeat (3) @(posedge clk);
    #1;
    cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    check("rst_ack_a", ack_a, 0);
    check("rst_dat_a", dat_a, 0);
    use_b = 1'b1;
    @(negedge clk);
    check("rst_ack_b", ack_b, 0);
    check("rst_dat_b", dat_b, 0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; rst = 1'b0; use_b = 1'b0;
    @(posedge clk); #1;

    fill_rand(64); access(1, 0, 64, -1, 0, -1);
    use_b = 1'b1;
    fill_rand(16); access(1, 0, 16, -1, 0, -1);
    use_b = 1'b0;

    bdat[0] = 32'hDEADBEEF; bsel[0] = 4'hF;
    access(1, 16, 1, -1, 0, -1);
    access(0, 16, 1, -1, 0, -1);
    bdat[0] = 32'h11223344; bsel[0] = 4'b0101;
    access(1, 16, 1, -1, 0, -1);
    access(0, 16, 1, -1, 0, -1);
    check("merge_model", mdl[0][16], 32'hDE22BE44);

    for (int i = 0; i < 4; i++) begin
      bdat[i] = 32'hA0 + 32'(i);
      bsel[i] = 4'hF;
    end
    access(1, 0, 4, -1, 0, -1);
    access(0, 0, 4, -1, 0, -1);

    use_b = 1'b1;
    bdat[0] = 32'd1; bdat[1] = 32'd2; bdat[2] = 32'd3;
    access(1, 15, 3, -1, 0, -1);
    access(0, 15, 3, -1, 0, -1);
    access(0, 2, 1, -1, 0, -1);
    access(0, 0, 4, 2, 2, -1);

    fill_rand(3);
    access(1, 0, 3, -1, 0, 1);
    access(0, 1, 1, -1, 0, -1);
    access(0, 0, 3, -1, 0, -1);

    for (int n = 0; n < 60; n++) begin
      int nb;
      int st_at;
      use_b = 1'($urandom_range(0, 1));
      nb    = $urandom_range(1, 6);
      st_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nb - 1) : -1;
      for (int i = 0; i < nb; i++) begin
        bdat[i] = $urandom;
        bsel[i] = 4'($urandom);
      end
      access(1'($urandom_range(0, 1)), $urandom_range(0, use_b ? 15 : 57), nb,
             st_at, $urandom_range(1, 3), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
